// File: rtl/spi_av_rx_fifo_reader_pkg.sv
// Shared definitions for the SpeedSPI RX FIFO reader: register map, bit positions, fetch states.
package spi_av_rx_fifo_reader_pkg;

  localparam logic [2:0] REG_RX_DATA   = 3'h2;
  localparam logic [2:0] REG_RX_STATUS = 3'h3;
  localparam logic [2:0] REG_RX_CTRL   = 3'h4;
  localparam logic [2:0] REG_RX_BURST  = 3'h5;

  localparam int CTRL_PREFETCH_EN = 0;
  localparam int CTRL_FLUSH       = 1;
  localparam int CTRL_CLR_ERR     = 2;

  localparam int STATUS_EMPTY     = 16;
  localparam int STATUS_FULL      = 17;
  localparam int STATUS_OVERFLOW  = 18;
  localparam int STATUS_UNDERFLOW = 19;
  localparam int STATUS_BUSY      = 20;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

  // Register bank hit: upper address bits zero, bank select matches, lower half of the bank.
  function automatic logic reg_hit(input logic [15:0] address, input logic [1:0] offset);
    return (address[15:6] == 10'd0) && (address[5:4] == offset) && !address[3];
  endfunction

endpackage

// File: rtl/spi_av_rx_fifo_reader_if.sv
// Avalon s0 slave port plus SPI engine receive handshake for the RX FIFO reader.
interface spi_av_rx_fifo_reader_if #(
  parameter int DATA_W = 8
);
  logic              avs_s0_read;
  logic              avs_s0_write;
  logic [15:0]       avs_s0_address;
  logic [31:0]       avs_s0_writedata;
  logic [31:0]       avs_s0_readdata;
  logic              read_start;
  logic [DATA_W-1:0] read_data;
  logic              read_save;

  // Interconnect / engine side.
  modport master (
    output avs_s0_read, avs_s0_write, avs_s0_address, avs_s0_writedata,
    output read_data, read_save,
    input  avs_s0_readdata, read_start
  );

  // Reader side.
  modport slave (
    input  avs_s0_read, avs_s0_write, avs_s0_address, avs_s0_writedata,
    input  read_data, read_save,
    output avs_s0_readdata, read_start
  );
endinterface

// File: rtl/spi_av_rx_fifo_reader_fifo.sv
// Synchronous RX FIFO with push/pop/flush; simultaneous push and pop is allowed even when full.
module spi_av_rx_fifo_reader_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally at the power-of-two depth; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; contents are only visible once level says so.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_av_rx_fifo_reader.sv
// Avalon-MM read path for the SpeedSPI controller: register decode, RX FIFO, fetch FSM, sticky errors.
//
//  state      | meaning
//  FETCH_IDLE | no transfer outstanding; may issue read_start
//  FETCH_WAIT | one transfer outstanding; waiting for read_save
module spi_av_rx_fifo_reader
  import spi_av_rx_fifo_reader_pkg::*;
#(
  parameter logic [1:0] OFFSET  = 2'd0,
  parameter int         DATA_W  = 8,
  parameter int         DEPTH   = 16,
  parameter int         BURST_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  spi_av_rx_fifo_reader_if.slave bus
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic               hit;
  logic [2:0]         reg_sel;
  logic               rd_data;
  logic               wr_ctrl;
  logic               wr_burst;
  logic               flush;
  logic               clr_err;
  logic               prefetch_en;
  logic [BURST_W-1:0] burst;
  logic               overflow;
  logic               underflow;
  logic               drop;
  logic [DATA_W-1:0]  head;
  logic [LW-1:0]      level;
  logic               full;
  logic               empty;
  logic               pop;
  logic               save_ok;
  logic               push;
  logic               ovf_set;
  logic               unf_set;
  fetch_state_e       state;
  fetch_state_e       state_next;
  logic               fire;
  logic               busy;
  logic [31:0]        status;
  logic [31:0]        rdata_next;
  logic               unused_wdata;

  assign hit      = reg_hit(bus.avs_s0_address, OFFSET);
  assign reg_sel  = bus.avs_s0_address[2:0];
  assign rd_data  = bus.avs_s0_read && hit && (reg_sel == REG_RX_DATA);
  assign wr_ctrl  = bus.avs_s0_write && hit && (reg_sel == REG_RX_CTRL);
  assign wr_burst = bus.avs_s0_write && hit && (reg_sel == REG_RX_BURST);
  assign flush    = wr_ctrl && bus.avs_s0_writedata[CTRL_FLUSH];
  assign clr_err  = wr_ctrl && bus.avs_s0_writedata[CTRL_CLR_ERR];
  assign unused_wdata = ^bus.avs_s0_writedata;

  // A popped slot can absorb a word saved in the same cycle, so full+pop still accepts the push.
  assign pop     = rd_data && !empty;
  assign save_ok = bus.read_save && !drop;
  assign push    = save_ok && !flush && (!full || pop);
  assign ovf_set = save_ok && !flush && full && !pop;
  assign unf_set = rd_data && empty;

  spi_av_rx_fifo_reader_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (bus.read_data),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_IDLE;
    else     state <= state_next;
  end

  // Fetch FSM next state: a flush abandons the outstanding transfer.
  always_comb begin
    state_next = state;
    case (state)
      FETCH_IDLE: if (fire) state_next = FETCH_WAIT;
      FETCH_WAIT: if (bus.read_save || flush) state_next = FETCH_IDLE;
      default:    state_next = FETCH_IDLE;
    endcase
  end

  // Fetch FSM outputs: no new fetch while a flushed transfer is still in flight.
  always_comb begin
    fire = 1'b0;
    busy = (state != FETCH_IDLE);
    if (state == FETCH_IDLE && !drop && !flush) begin
      if (prefetch_en) fire = (burst != '0) && !full;
      else             fire = rd_data && (pop || !full);
    end
  end

  // read_start is a registered single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) bus.read_start <= 1'b0;
    else     bus.read_start <= fire;
  end

  // Control and burst registers; a host write to BURST overrides the fetch decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      prefetch_en <= 1'b0;
      burst       <= '0;
    end else begin
      if (wr_ctrl) prefetch_en <= bus.avs_s0_writedata[CTRL_PREFETCH_EN];
      if (flush)                      burst <= '0;
      else if (wr_burst)              burst <= bus.avs_s0_writedata[BURST_W-1:0];
      else if (fire && prefetch_en)   burst <= burst - 1'b1;
    end
  end

  // Sticky error flags; a set event beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (unf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  // Drop marks that the next read_save belongs to a transfer abandoned by flush.
  always_ff @(posedge clk) begin
    if (rst)                                                drop <= 1'b0;
    else if (flush && state == FETCH_WAIT && !bus.read_save) drop <= 1'b1;
    else if (bus.read_save)                                 drop <= 1'b0;
  end

  // Status word and read mux.
  always_comb begin
    status                   = '0;
    status[8:0]              = 9'(level);
    status[STATUS_EMPTY]     = empty;
    status[STATUS_FULL]      = full;
    status[STATUS_OVERFLOW]  = overflow;
    status[STATUS_UNDERFLOW] = underflow;
    status[STATUS_BUSY]      = busy;
    rdata_next = '0;
    if (bus.avs_s0_read && hit) begin
      case (reg_sel)
        REG_RX_DATA:   rdata_next = empty ? '0 : 32'(head);
        REG_RX_STATUS: rdata_next = status;
        REG_RX_CTRL:   rdata_next = {31'd0, prefetch_en};
        REG_RX_BURST:  rdata_next = 32'(burst);
        default:       rdata_next = '0;
      endcase
    end
  end

  // Registered read data, zero whenever there is no read.
  always_ff @(posedge clk) begin
    if (rst) bus.avs_s0_readdata <= '0;
    else     bus.avs_s0_readdata <= rdata_next;
  end

endmodule

// File: tb/tb_spi_av_rx_fifo_reader.sv
// Directed self-checking bench for spi_av_rx_fifo_reader (OFFSET 0, DATA_W 8, DEPTH 16).
module tb_spi_av_rx_fifo_reader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_av_rx_fifo_reader_if #(.DATA_W(8)) bus ();

  spi_av_rx_fifo_reader #(
    .OFFSET  (2'd0),
    .DATA_W  (8),
    .DEPTH   (16),
    .BURST_W (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [15:0] A_DATA   = 16'h0002;
  localparam logic [15:0] A_STATUS = 16'h0003;
  localparam logic [15:0] A_CTRL   = 16'h0004;
  localparam logic [15:0] A_BURST  = 16'h0005;

  int nerr = 0;
  int nchk = 0;
  int start_cnt = 0;
  int s0;
  logic [31:0] exp_q [$];
  logic [7:0]  mdl [$];
  logic [31:0] e;

  always @(negedge clk) if (!rst && bus.read_start) start_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic avs_rd(input logic [15:0] addr, input logic [31:0] exp, input string tag);
    bus.avs_s0_address = addr;
    bus.avs_s0_read    = 1'b1;
    exp_q.push_back(exp);
    cyc();
    bus.avs_s0_read = 1'b0;
    check(tag, bus.avs_s0_readdata, exp_q.pop_front());
  endtask

  task automatic avs_wr(input logic [15:0] addr, input logic [31:0] data);
    bus.avs_s0_address   = addr;
    bus.avs_s0_writedata = data;
    bus.avs_s0_write     = 1'b1;
    cyc();
    bus.avs_s0_write = 1'b0;
  endtask

  task automatic save(input logic [7:0] w);
    bus.read_data = w;
    bus.read_save = 1'b1;
    cyc();
    bus.read_save = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.read_start) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    bus.avs_s0_read      = 1'b0;
    bus.avs_s0_write     = 1'b0;
    bus.avs_s0_address   = '0;
    bus.avs_s0_writedata = '0;
    bus.read_data        = '0;
    bus.read_save        = 1'b0;
    rst = 1'b1;
    repeat (3) cyc();
    check("rst_rdata", bus.avs_s0_readdata, 32'd0);
    check("rst_start", 32'(bus.read_start), 32'd0);
    rst = 1'b0;

    // Reset state and decode misses
    avs_rd(A_STATUS, 32'h0001_0000, "rst_status");
    avs_rd(16'h0043, 32'd0, "miss_hi_addr");
    avs_rd(16'h000B, 32'd0, "miss_bit3");
    avs_rd(16'h0007, 32'd0, "miss_reg7");
    check("rst_no_start", 32'(start_cnt), 32'd0);

    // Manual mode: empty read underflows and launches one transfer
    avs_rd(A_DATA, 32'd0, "data_empty");
    avs_rd(A_STATUS, 32'h0019_0000, "status_unf_busy");
    check("manual_start1", 32'(start_cnt), 32'd1);
    save(8'hA5); mdl.push_back(8'hA5);
    avs_rd(A_STATUS, 32'h0008_0001, "status_lvl1");
    e = 32'(mdl.pop_front());
    avs_rd(A_DATA, e, "data_a5");
    cyc();
    check("manual_start2", 32'(start_cnt), 32'd2);
    save(8'h3C); mdl.push_back(8'h3C);
    avs_wr(A_CTRL, 32'h4);
    avs_rd(A_STATUS, 32'h0000_0001, "status_clr_err");
    avs_wr(A_CTRL, 32'h2); mdl.delete();
    avs_rd(A_STATUS, 32'h0001_0000, "status_flushed");

    // Prefetch burst of 20 into a 16-deep FIFO
    s0 = start_cnt;
    avs_wr(A_BURST, 32'd20);
    avs_wr(A_CTRL, 32'h1);
    for (int i = 0; i < 16; i++) begin
      wait_start("pf_start");
      save(8'h10 + 8'(i)); mdl.push_back(8'h10 + 8'(i));
    end
    repeat (4) cyc();
    check("pf_start_cnt", 32'(start_cnt - s0), 32'd16);
    avs_rd(A_STATUS, 32'h0002_0010, "pf_status_full");
    avs_rd(A_BURST, 32'd4, "pf_burst_left");
    avs_rd(A_CTRL, 32'd1, "ctrl_readback");

    // Saves while full overflow without disturbing contents
    repeat (3) save(8'hEE);
    avs_rd(A_STATUS, 32'h0006_0010, "status_ovf");
    avs_wr(A_CTRL, 32'h5);
    avs_rd(A_STATUS, 32'h0002_0010, "status_ovf_clr");

    // Draining four words lets the remaining burst complete
    s0 = start_cnt;
    for (int i = 0; i < 4; i++) begin
      e = 32'(mdl.pop_front());
      avs_rd(A_DATA, e, "drain_data");
      wait_start("refill_start");
      save(8'h20 + 8'(i)); mdl.push_back(8'h20 + 8'(i));
    end
    repeat (3) cyc();
    check("refill_cnt", 32'(start_cnt - s0), 32'd4);
    avs_rd(A_BURST, 32'd0, "burst_zero");
    avs_rd(A_STATUS, 32'h0002_0010, "refill_full");

    // Flush while a manual transfer is outstanding
    avs_wr(A_CTRL, 32'h0);
    e = 32'(mdl.pop_front());
    avs_rd(A_DATA, e, "pre_flush_data");
    avs_wr(A_CTRL, 32'h2); mdl.delete();
    avs_rd(A_STATUS, 32'h0001_0000, "flush_idle");
    save(8'h77);
    avs_rd(A_STATUS, 32'h0001_0000, "late_save_dropped");
    save(8'h78); mdl.push_back(8'h78);
    avs_rd(A_STATUS, 32'h0000_0001, "next_save_kept");
    e = 32'(mdl.pop_front());
    avs_rd(A_DATA, e, "data_78");
    save(8'h79);
    avs_wr(A_CTRL, 32'h2); mdl.delete();

    // Concurrent push and pop at level 5, running the pointers past the wrap
    for (int i = 0; i < 5; i++) begin
      save(8'h40 + 8'(i)); mdl.push_back(8'h40 + 8'(i));
    end
    for (int i = 0; i < 20; i++) begin
      bus.avs_s0_address = A_DATA;
      bus.avs_s0_read    = 1'b1;
      bus.read_data      = 8'h50 + 8'(i);
      bus.read_save      = 1'b1;
      exp_q.push_back(32'(mdl.pop_front()));
      mdl.push_back(8'h50 + 8'(i));
      cyc();
      bus.avs_s0_read = 1'b0;
      bus.read_save   = 1'b0;
      check("pushpop_data", bus.avs_s0_readdata, exp_q.pop_front());
    end
    cyc();
    check("idle_rdata", bus.avs_s0_readdata, 32'd0);
    avs_rd(A_STATUS, 32'h0000_0005, "pushpop_level");
    for (int i = 0; i < 5; i++) begin
      e = 32'(mdl.pop_front());
      avs_rd(A_DATA, e, "wrap_drain");
    end
    avs_rd(A_STATUS, 32'h0011_0000, "final_status");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
